// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, immediate formats and
// the decoded-instruction bundle passed from decode to register-read/execute.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASS_B = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction decoder. RV32M encodings on OP are
// decoded only when DECODE_RV32M_EN is defined; otherwise they are illegal.
module decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  imm_fmt_t   fmt;
  alu_op_t    op;
  logic use_rs1, use_rs2, use_rd, shamt_imm, bad;
  logic wr, mrd, mwr, br, jmp, src_imm;

  assign opcode = inst[6:0];
  assign funct7 = inst[31:25];
  assign f3     = inst[14:12];

  // Opcode/funct decode into format, operation and raw control intent.
  always_comb begin
    fmt = IMM_NONE;
    op = ALU_ADD;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    shamt_imm = 1'b0; bad = 1'b0;
    wr = 1'b0; mrd = 1'b0; mwr = 1'b0; br = 1'b0; jmp = 1'b0; src_imm = 1'b0;
    case (opcode)
      OPC_LUI:   begin fmt = IMM_U; use_rd = 1'b1; wr = 1'b1; src_imm = 1'b1; op = ALU_PASS_B; end
      OPC_AUIPC: begin fmt = IMM_U; use_rd = 1'b1; wr = 1'b1; src_imm = 1'b1; end
      OPC_JAL:   begin fmt = IMM_J; use_rd = 1'b1; wr = 1'b1; jmp = 1'b1; src_imm = 1'b1; end
      OPC_JALR: begin
        fmt = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; jmp = 1'b1; src_imm = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; br = 1'b1;
        case (f3)
          3'b000, 3'b001: op = ALU_SUB;
          3'b100, 3'b101: op = ALU_SLT;
          3'b110, 3'b111: op = ALU_SLTU;
          default:        bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; mrd = 1'b1; src_imm = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
          default:                                bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; mwr = 1'b1; src_imm = 1'b1;
        bad = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1; src_imm = 1'b1;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin op = ALU_SLL; shamt_imm = 1'b1; bad = (funct7 != F7_BASE); end
          3'b101: begin
            shamt_imm = 1'b1;
            if (funct7 == F7_BASE) begin
              op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              op = ALU_SRA;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; wr = 1'b1;
        if (funct7 == F7_BASE) begin
          case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (f3)
            3'b000:  op = ALU_SUB;
            3'b101:  op = ALU_SRA;
            default: bad = 1'b1;
          endcase
        end else if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
          case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
          endcase
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OPC_FENCE:  bad = (f3 != 3'b000);
      // ECALL/EBREAK and CSR accesses are not executed by this core.
      OPC_SYSTEM: begin fmt = IMM_I; bad = 1'b1; end
      default:    bad = 1'b1;
    endcase
    if ((inst[1:0] != 2'b11) || (inst == 32'h0000_0000)) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
  end

  // Assemble the output bundle; illegal instructions keep fields but lose side effects.
  always_comb begin
    dec = '0;
    dec.pc          = pc;
    dec.rs1         = use_rs1 ? inst[19:15] : 5'd0;
    dec.rs2         = use_rs2 ? inst[24:20] : 5'd0;
    dec.rd          = use_rd  ? inst[11:7]  : 5'd0;
    dec.imm         = shamt_imm ? {27'd0, inst[24:20]} : gen_imm(inst, fmt);
    dec.funct3      = f3;
    dec.alu_op      = op;
    dec.reg_write   = wr && !bad && (dec.rd != 5'd0);
    dec.mem_read    = mrd && !bad;
    dec.mem_write   = mwr && !bad;
    dec.branch      = br && !bad;
    dec.jump        = jmp && !bad;
    dec.alu_src_imm = src_imm;
    dec.illegal     = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: output register plus one-entry skid buffer,
// registered in_ready and synchronous flush. Optional RV32M via DECODE_RV32M_EN.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      funct3,
  output logic [4:0]      alu_op,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src_imm,
  output logic            illegal
);

  decoded_t dec;
  decoded_t out_d, out_q, skid_d, skid_q;
  logic out_valid_d, out_valid_q;
  logic skid_valid_d, skid_valid_q;
  logic in_ready_d, in_ready_q;
  logic in_fire, out_fire;

  decode_comb u_decode_comb (
    .inst (inst),
    .pc   (pc),
    .dec  (dec)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Next-state for OUT/SKID; SKID only fills while OUT is held, and drains first.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign imm         = out_q.imm;
  assign funct3      = out_q.funct3;
  assign alu_op      = out_q.alu_op;
  assign reg_write   = out_q.reg_write;
  assign mem_read    = out_q.mem_read;
  assign mem_write   = out_q.mem_write;
  assign branch      = out_q.branch;
  assign jump        = out_q.jump;
  assign alu_src_imm = out_q.alu_src_imm;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (honours DECODE_RV32M_EN).
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic [2:0]  funct3;
  logic reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal;
  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .funct3(funct3), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .alu_src_imm(alu_src_imm), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] flags();
    return {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat with out_ready high and leave the stage idle afterwards.
  task automatic one_beat(input logic [31:0] i, input logic [31:0] p);
    inst = i; pc = p; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = 32'h0; pc = 32'h0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL reset_hs: got %b want 01", {out_valid, in_ready}); end
    n_cmp++; if ({out_pc, imm, rd, rs1, rs2} !== 79'd0) begin n_err++; $display("FAIL reset_data: pc %h imm %h", out_pc, imm); end
    n_cmp++; if ({alu_op, flags()} !== {ALU_ADD, 7'b0000000}) begin n_err++; $display("FAIL reset_ctrl: got %h", {alu_op, flags()}); end
  endtask

  task automatic test_alu_imm();
    one_beat(32'h0050_0093, 32'h0000_0010);
    n_cmp++; if ({out_valid, rd, rs1, rs2} !== {1'b1, 5'd1, 5'd0, 5'd0}) begin n_err++; $display("FAIL addi_regs: rd %0d rs1 %0d v %b", rd, rs1, out_valid); end
    n_cmp++; if ({imm, alu_op, flags()} !== {32'd5, ALU_ADD, 7'b1000010}) begin n_err++; $display("FAIL addi_ctrl: imm %h op %0d flags %b", imm, alu_op, flags()); end
    one_beat(32'h0050_0013, 32'h0000_0014);
    n_cmp++; if (flags() !== 7'b0000010) begin n_err++; $display("FAIL addi_x0: flags %b want 0000010", flags()); end
    one_beat(32'h4031_5093, 32'h0000_0018);
    n_cmp++; if ({imm, alu_op, flags(), rs1} !== {32'd3, ALU_SRA, 7'b1000010, 5'd2}) begin n_err++; $display("FAIL srai: imm %h op %0d flags %b", imm, alu_op, flags()); end
    one_beat(32'h4031_1093, 32'h0000_001C);
    n_cmp++; if ({reg_write, illegal} !== 2'b01) begin n_err++; $display("FAIL bad_slli: got %b want 01", {reg_write, illegal}); end
    one_beat(32'h1234_52B7, 32'h0000_0020);
    n_cmp++; if ({imm, rd, rs1, flags()} !== {32'h1234_5000, 5'd5, 5'd0, 7'b1000010}) begin n_err++; $display("FAIL lui: imm %h rd %0d flags %b", imm, rd, flags()); end
  endtask

  task automatic test_store_branch();
    one_beat(32'h0020_A423, 32'h0000_0040);
    n_cmp++; if ({rs1, rs2, rd, imm, funct3} !== {5'd1, 5'd2, 5'd0, 32'd8, 3'd2}) begin n_err++; $display("FAIL sw_fields: rs1 %0d rs2 %0d rd %0d imm %h", rs1, rs2, rd, imm); end
    n_cmp++; if (flags() !== 7'b0010010) begin n_err++; $display("FAIL sw_flags: got %b want 0010010", flags()); end
    one_beat(32'hFE00_0EE3, 32'h0000_0100);
    n_cmp++; if ({imm, out_pc, flags()} !== {32'hFFFF_FFFC, 32'h0000_0100, 7'b0001000}) begin n_err++; $display("FAIL beq: imm %h pc %h flags %b", imm, out_pc, flags()); end
  endtask

  task automatic test_illegal();
    one_beat(32'h0000_0000, 32'h0000_0200);
    n_cmp++; if ({out_valid, flags()} !== {1'b1, 7'b0000001}) begin n_err++; $display("FAIL zero_inst: got %b want 10000001", {out_valid, flags()}); end
    one_beat(32'h0000_0073, 32'h0000_0204);
    n_cmp++; if (flags() !== 7'b0000001) begin n_err++; $display("FAIL ecall: got %b want 0000001", flags()); end
    one_beat(32'h0050_0091, 32'h0000_0208);
    n_cmp++; if ({reg_write, illegal} !== 2'b01) begin n_err++; $display("FAIL compressed: got %b want 01", {reg_write, illegal}); end
  endtask

  task automatic test_mul();
    one_beat(32'h0220_81B3, 32'h0000_0300);
    n_cmp++; if ({rd, rs1, rs2} !== {5'd3, 5'd1, 5'd2}) begin n_err++; $display("FAIL mul_regs: rd %0d rs1 %0d rs2 %0d", rd, rs1, rs2); end
`ifdef DECODE_RV32M_EN
    n_cmp++; if ({alu_op, flags()} !== {ALU_MUL, 7'b1000000}) begin n_err++; $display("FAIL mul_en: op %0d flags %b", alu_op, flags()); end
`else
    n_cmp++; if ({reg_write, illegal} !== 2'b01) begin n_err++; $display("FAIL mul_dis: got %b want 01", {reg_write, illegal}); end
`endif
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13}; pc = 32'h400 + 32'(4 * i); in_valid = 1'b1;
      tick();
      n_cmp++; if ({out_valid, in_ready, out_pc, imm} !== {2'b11, 32'h400 + 32'(4 * i), 32'(i + 1)}) begin
        n_err++; $display("FAIL thru_%0d: v %b r %b pc %h imm %h", i, out_valid, in_ready, out_pc, imm);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL thru_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    inst = 32'h0050_0093; pc = 32'h500; in_valid = 1'b1; tick();
    n_cmp++; if ({out_valid, in_ready, out_pc} !== {2'b11, 32'h500}) begin n_err++; $display("FAIL b2b_a: v %b r %b pc %h", out_valid, in_ready, out_pc); end
    inst = 32'h0070_0113; pc = 32'h504; tick();
    n_cmp++; if ({out_valid, in_ready, out_pc} !== {2'b10, 32'h500}) begin n_err++; $display("FAIL b2b_b: v %b r %b pc %h", out_valid, in_ready, out_pc); end
    inst = 32'h0090_0193; pc = 32'h508; tick();
    n_cmp++; if ({in_ready, out_pc, rd} !== {1'b0, 32'h500, 5'd1}) begin n_err++; $display("FAIL b2b_stall: r %b pc %h rd %0d", in_ready, out_pc, rd); end
    out_ready = 1'b1; tick();
    n_cmp++; if ({out_valid, in_ready, out_pc, imm} !== {2'b11, 32'h504, 32'd7}) begin n_err++; $display("FAIL b2b_2nd: v %b r %b pc %h imm %h", out_valid, in_ready, out_pc, imm); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_pc, imm, rd} !== {1'b1, 32'h508, 32'd9, 5'd3}) begin n_err++; $display("FAIL b2b_3rd: v %b pc %h imm %h", out_valid, out_pc, imm); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    inst = 32'h0050_0093; pc = 32'h600; in_valid = 1'b1; tick();
    pc = 32'h604; tick();
    flush = 1'b1; pc = 32'h608; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready, out_pc} !== {2'b01, 32'h600}) begin n_err++; $display("FAIL flush_full: v %b r %b pc %h", out_valid, in_ready, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost_%0d: out_valid %b pc %h", i, out_valid, out_pc); end
    end
    flush = 1'b1; in_valid = 1'b1; pc = 32'h700; tick();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: out_valid %b pc %h", out_valid, out_pc); end
    pc = 32'h704; tick();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h704}) begin n_err++; $display("FAIL flush_recover: v %b pc %h", out_valid, out_pc); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    inst = 32'h1234_52B7; pc = 32'h800; in_valid = 1'b1; tick();
    pc = 32'h804; tick();
    reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready, out_pc, imm, rd, flags()} !== {2'b01, 32'h0, 32'h0, 5'd0, 7'd0}) begin
      n_err++; $display("FAIL reset_mid: v %b r %b pc %h imm %h", out_valid, in_ready, out_pc, imm);
    end
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_store_branch();
    test_illegal();
    test_mul();
    test_throughput();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I decode pipeline stage, directly downstream of the fetch stage. Accepts one fetched instruction word and its PC per handshake and registers the decoded result: register indices, sign-extended immediate, ALU operation and control flags. Output goes to the register-read/execute stage. A one-entry skid buffer keeps `in_ready` registered, and a synchronous flush discards in-flight instructions on redirects.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Only 32 is supported.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous discard of all held instructions.
- `in_valid` input 1: `inst`/`pc` are valid.
- `in_ready` output 1: stage can accept. Registered.
- `inst` input 32: instruction word.
- `pc` input 32: address of `inst`.
- `out_valid` output 1: decoded fields are valid.
- `out_ready` input 1: downstream accepts.
- `out_pc` output 32: PC of the decoded instruction.
- `rs1`, `rs2`, `rd` output 5: register indices. Forced to 0 when unused by the format.
- `imm` output 32: sign-extended immediate for the I/S/B/U/J formats. 0 for R-type.
- `funct3` output 3: raw `inst[14:12]`.
- `alu_op` output 5: `alu_op_t` encoding.
- Control flags, output 1 each: `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `alu_src_imm`, `illegal`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- State is an output register (OUT) plus a skid register (SKID), each with its own valid bit.
- Decoding is combinational on `inst`. The result is written into OUT, or into SKID when OUT is held.
- Accepted beat when OUT is empty, or when OUT transfers out in the same cycle: write OUT.
- Accepted beat when OUT is held (`out_valid && !out_ready`): write SKID. `in_ready` drops to 0 the next cycle.
- OUT transfers out while SKID is full: SKID moves into OUT and `in_ready` returns to 1 the next cycle.
- Order is strictly FIFO. No beat is lost or duplicated.
- `illegal=1` for:
  - unknown opcode;
  - bad funct3/funct7 combination;
  - `inst[1:0]!=2'b11`;
  - `inst==0`.
- When `illegal=1`: `reg_write`, `mem_*`, `branch` and `jump` are 0, and the instruction still flows through.
- `rd==0` forces `reg_write=0`.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (decoded as NOP), SYSTEM (ECALL/EBREAK flagged `illegal`).
- Shift-immediate instructions: `imm` is `{27'b0, inst[24:20]}`. A nonzero `inst[31:25]` other than SRAI's `0100000` is illegal.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented at `out_*` after edge N.
- Throughput is 1 instruction/cycle when `out_ready` is held high.
- Reset values:
  - `out_valid=0`, SKID empty, `in_ready=1`;
  - all data outputs 0, `alu_op=ALU_ADD`, all flags 0.
- `reset` has priority over `flush`, and `flush` has priority over handshakes.
- `flush=1` at an edge:
  - OUT and SKID are emptied;
  - any `in_valid` beat in that cycle is dropped;
  - `in_ready=1` the following cycle;
  - data outputs keep their values; only the valid bits clear.
- Reset asserted mid-operation behaves like flush and also zeroes the data outputs.
- `out_*` fields are stable while `out_valid && !out_ready`.

## Configuration
- Macro `DECODE_RV32M_EN`.
- Defined: OP with `funct7=0000001` decodes to the MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU `alu_op` values.
- Undefined: those encodings raise `illegal=1`, and the M entries of `alu_op_t` are still declared but never produced.

## Structure
- `riscv_pkg` holds:
  - opcode constants (`OPC_LUI` … `OPC_SYSTEM`);
  - the `alu_op_t` enum;
  - the `imm_fmt_t` enum (`IMM_I/S/B/U/J/NONE`);
  - a `decoded_t` struct bundling every output field except the valid bit.
- Sub-module `decode_comb`: a purely combinational `inst` → `decoded_t` mapping.
- `decode_stage` contains only the OUT/SKID registers, the handshake and the flush logic.

## Test plan
- `0x00500093` (addi x1,x0,5), `out_ready=1` → next cycle: `rd=1`, `rs1=0`, `imm=5`, `alu_op=ALU_ADD`, `alu_src_imm=1`, `reg_write=1`, `illegal=0`.
- `0x0020A423` (sw x2,8(x1)) → `rs1=1`, `rs2=2`, `imm=8`, `mem_write=1`, `reg_write=0`, `rd=0`.
- `0xFE000EE3` (beq x0,x0,-4) at `pc=0x100` → `imm=0xFFFFFFFC`, `branch=1`, `out_pc=0x100`; also `inst=0x00000000` → `illegal=1`, all flags 0.
- Three back-to-back beats with `out_ready=0` for 3 cycles → `in_ready` falls after the 2nd beat and the 3rd beat stalls. On release, the three beats emerge in order on consecutive cycles.
- OUT and SKID both full, `flush=1` with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, and the flushed-cycle beat never appears.
- `0x022081B3` (mul x3,x1,x2) → `alu_op=ALU_MUL`, `illegal=0` with `DECODE_RV32M_EN`; `illegal=1`, `reg_write=0` without it.
